// File: rtl/veri_risc.sv
// Minimal 8-bit accumulator CPU: one instruction per 8-phase sequence, with a
// 32x8 unified instruction/data memory that has a combinational read port.

module veri_risc_mem (
  input  logic       clk_i,
  input  logic       wr_i,
  input  logic [4:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  reg [7:0] array [0:31];

  assign data_o = array[addr_i];

  always_ff @(posedge clk_i) begin
    if (wr_i) array[addr_i] <= data_i;
  end

endmodule

module veri_risc (
  input  logic clk,
  input  logic rst,
  output logic halt
);

  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_e;

  typedef enum logic [2:0] {
    HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
  } op_e;

  phase_e      phase_q, phase_d;
  logic [4:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  acc_q, acc_d;
  logic        halted_q, halted_d;

  op_e         opcode;
  logic [4:0]  operand;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_wr;
  logic        zero;

  function automatic logic [7:0] alu(input op_e op, input logic [7:0] a,
                                     input logic [7:0] d);
    logic [7:0] r;
    unique case (op)
      ADD:     r = a + d;
      AND:     r = a & d;
      XOR:     r = a ^ d;
      LDA:     r = d;
      default: r = a;
    endcase
    return r;
  endfunction

  assign opcode   = op_e'(ir_q[7:5]);
  assign operand  = ir_q[4:0];
  assign zero     = (acc_q == 8'h00);
  assign mem_addr = phase_q[2] ? operand : pc_q;
  // A reset edge must not let a pending STO land in memory.
  assign mem_wr   = !rst && (phase_q == STORE) && (opcode == STO);
  assign halt     = halted_q || ((phase_q == OP_ADDR) && (opcode == HLT));

  veri_risc_mem memory_inst (
    .clk_i  (clk),
    .wr_i   (mem_wr),
    .addr_i (mem_addr),
    .data_i (acc_q),
    .data_o (mem_rdata)
  );

  always_comb begin
    phase_d  = halt ? phase_q : phase_e'(phase_q + 3'd1);
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    halted_d = halted_q;
    unique case (phase_q)
      INST_LOAD, IDLE: ir_d = mem_rdata;
      OP_ADDR: begin
        if (opcode == HLT) halted_d = 1'b1;
        else               pc_d     = pc_q + 5'd1;
      end
      ALU_OP: begin
        if (opcode == SKZ && zero) pc_d = pc_q + 5'd1;
        else if (opcode == JMP)    pc_d = operand;
      end
      STORE: begin
        if (opcode == ADD || opcode == AND || opcode == XOR || opcode == LDA)
          acc_d = alu(opcode, acc_q, mem_rdata);
        else if (opcode == JMP)
          pc_d = operand;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      pc_q     <= 5'd0;
      ir_q     <= 8'h00;
      acc_q    <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_veri_risc.sv
// Scoreboarded bench for veri_risc: an instruction-level interpreter predicts
// halt timing, final accumulator and final memory image for each program.

module tb_veri_risc;

  localparam int LIMIT    = 2000;
  localparam int MAX_INST = 150;

  typedef struct packed {
    logic [31:0]  edges;
    logic [7:0]   acc;
    logic [255:0] mem;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;

  exp_t sb[$];
  logic [7:0] prog [32];
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   go     = 1'b0;
  bit   done   = 1'b0;

  veri_risc dut (.clk(clk), .rst(rst), .halt(halt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Instruction-level interpreter: fetch, bump pc, then apply the opcode.
  function automatic exp_t model(input logic [255:0] img, output bit ok);
    logic [7:0] m [32];
    logic [4:0] pc;
    logic [7:0] acc;
    logic [7:0] inst;
    exp_t e;
    for (int i = 0; i < 32; i++) m[i] = img[i*8 +: 8];
    pc = 5'd0; acc = 8'h00; ok = 1'b0; e = '0;
    for (int k = 0; k < MAX_INST; k++) begin
      inst = m[pc];
      if (inst[7:5] == 3'd0) begin
        ok = 1'b1;
        e.edges = 32'(8 * k + 4);
        break;
      end
      pc = pc + 5'd1;
      case (inst[7:5])
        3'd1: if (acc == 8'h00) pc = pc + 5'd1;
        3'd2: acc = acc + m[inst[4:0]];
        3'd3: acc = acc & m[inst[4:0]];
        3'd4: acc = acc ^ m[inst[4:0]];
        3'd5: acc = m[inst[4:0]];
        3'd6: m[inst[4:0]] = acc;
        default: pc = inst[4:0];
      endcase
    end
    e.acc = acc;
    for (int i = 0; i < 32; i++) e.mem[i*8 +: 8] = m[i];
    return e;
  endfunction

  function automatic logic [255:0] prog_img();
    logic [255:0] img;
    for (int i = 0; i < 32; i++) img[i*8 +: 8] = prog[i];
    return img;
  endfunction

  task automatic clr_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  function automatic logic [7:0] ins(input int op, input int a);
    return {3'(op), 5'(a)};
  endfunction

  // Load program under reset, predict, release reset and hand off to monitor.
  task automatic run_prog(input string name);
    exp_t e;
    bit ok;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) dut.memory_inst.array[i] = prog[i];
    @(posedge clk); #1;
    chk({name, "/reset_halt"}, 32'(halt), 32'd0);
    e = model(prog_img(), ok);
    if (!ok) $display("FAIL %s/model: program does not halt, got 0, required 1", name);
    sb.push_back(e);
    rst = 1'b0;
    go  = 1'b1;
    wait (done);
    go  = 1'b0;
    wait (!done);
  endtask

  task automatic partial_run(input int n);
    for (int i = 0; i < 32; i++) dut.memory_inst.array[i] = prog[i];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: counts edges until halt is seen, then checks against scoreboard.
  initial begin
    exp_t e;
    int   edges;
    logic [255:0] act_mem;
    forever begin
      wait (go);
      edges = 0;
      while (edges < LIMIT) begin
        @(posedge clk); #1;
        edges++;
        if (halt) break;
      end
      if (sb.size() == 0) begin
        $display("FAIL scoreboard: empty queue, got 0 entries, required 1");
        $fatal(1, "scoreboard underflow");
      end
      e = sb.pop_front();
      chk("halt_edge", 32'(edges), e.edges);
      repeat (9) @(posedge clk);
      #1;
      chk("halt_held", 32'(halt), 32'd1);
      chk("acc", 32'(dut.acc_q), 32'(e.acc));
      for (int i = 0; i < 32; i++) act_mem[i*8 +: 8] = dut.memory_inst.array[i];
      n_tot++;
      if (act_mem === e.mem) n_pass++;
      else begin
        for (int i = 0; i < 32; i++)
          if (act_mem[i*8 +: 8] !== e.mem[i*8 +: 8]) begin
            $display("FAIL mem[%0d]: got %0h, required %0h", i,
                     act_mem[i*8 +: 8], e.mem[i*8 +: 8]);
            break;
          end
      end
      done = 1'b1;
      wait (!go);
      done = 1'b0;
    end
  end

  initial begin
    exp_t e;
    bit ok;
    int tries;

    clr_prog();
    run_prog("hlt");

    clr_prog();
    prog[0] = ins(7, 2); prog[1] = ins(7, 2);
    run_prog("jmp");

    clr_prog();
    prog[0] = ins(1, 0); prog[1] = ins(7, 2);
    run_prog("skz");

    clr_prog();
    prog[0] = ins(5, 5); prog[1] = ins(1, 0); prog[5] = 8'h01;
    run_prog("skz_lda");

    clr_prog();
    prog[0] = ins(5, 7); prog[1] = ins(6, 8); prog[2] = ins(5, 8);
    prog[3] = ins(1, 0); prog[7] = 8'h01;
    run_prog("sto_lda");

    for (int v = 0; v < 2; v++) begin
      clr_prog();
      prog[0] = ins(5, 20); prog[1] = ins(v == 0 ? 3 : 4, 21);
      prog[2] = ins(1, 0);  prog[3] = ins(7, 5);
      prog[5] = ins(v == 0 ? 3 : 4, 22);
      prog[6] = ins(1, 0);  prog[8] = ins(7, 10);
      prog[20] = (v == 0) ? 8'hFF : 8'h55;
      prog[21] = (v == 0) ? 8'h01 : 8'h54;
      prog[22] = (v == 0) ? 8'hFE : 8'h01;
      run_prog(v == 0 ? "and" : "xor");
    end

    clr_prog();
    prog[0] = ins(5, 20); prog[1] = ins(2, 21); prog[2] = ins(1, 0);
    prog[4] = ins(2, 21); prog[5] = ins(1, 0);
    prog[20] = 8'hFF; prog[21] = 8'h01;
    run_prog("add_wrap");

    for (int t = 0; t < 16; t++) begin
      tries = 0;
      do begin
        for (int i = 0; i < 32; i++)
          prog[i] = (i < 20) ? ins($urandom_range(0, 7), $urandom_range(0, 31))
                             : 8'($urandom);
        prog[0] = ins(5, $urandom_range(20, 31));
        e = model(prog_img(), ok);
        tries++;
      end while (!ok && tries < 100);
      if (!ok) begin
        clr_prog();
        prog[0] = ins(5, 20); prog[20] = 8'($urandom);
      end
      // Every fourth program is first interrupted by a reset mid-instruction.
      if (t % 4 == 3) partial_run($urandom_range(5, 30));
      run_prog("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/veri_risc.md
Name: veri_risc

Overview:
- Minimal 8-bit accumulator RISC CPU with an on-chip 32x8 unified instruction/data memory.
- Executes one instruction per 8 clock cycles, using an 8-phase sequencer.
- Top-level block. Its only output is the halt flag; programs are preloaded directly into the internal memory array by the bench.

Parameters:
- none (address width fixed at 5, data width fixed at 8, opcode width fixed at 3)

Ports:
- clk   input  1  rising-edge clock.
- rst   input  1  synchronous, active-high reset.
- halt  output 1  high once an HLT instruction has reached phase 4; held until reset.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high.
- Reset state, applied at a rising edge with rst=1:
  - phase=0, pc=0, ir=0, acc=0, halted=0, so halt=0.
  - Memory contents are unchanged by reset.
- Memory:
  - Internal instance memory_inst, containing reg [7:0] array[0:31]. Both names are mandatory so benches can preload via hierarchical access.
  - Asynchronous (combinational) read of array[addr].
  - Synchronous write at the rising edge when wr=1.
- Instruction format: opcode=ir[7:5], operand=ir[4:0].
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Address mux: addr=pc in phases 0-3; addr=ir[4:0] in phases 4-7.
- Phase counter: 3 bits, increments every clock and wraps 7->0. It freezes at phase 4 when halted.
- Per-phase actions (each register update takes effect at the end of the listed phase's clock):
  - 0 INST_ADDR: no register update.
  - 1 INST_FETCH: memory read of mem[pc].
  - 2 INST_LOAD: ir <= mem[pc].
  - 3 IDLE: ir <= mem[pc] (same value).
  - 4 OP_ADDR:
    - If opcode==HLT: halt asserts combinationally in this phase and the halted flag sets; pc is NOT incremented.
    - Otherwise: pc <= pc+1.
  - 5 OP_FETCH: operand read of mem[ir[4:0]] for ADD/AND/XOR/LDA.
  - 6 ALU_OP:
    - SKZ with acc==0: pc <= pc+1.
    - JMP: pc <= ir[4:0].
  - 7 STORE:
    - ADD/AND/XOR/LDA: acc <= alu_out.
    - STO: mem[ir[4:0]] <= acc.
    - JMP: pc <= ir[4:0] (same value again).
- ALU (8-bit; operand is the memory data):
  - ADD: acc+data, modulo 256, carry discarded.
  - AND: acc&data.
  - XOR: acc^data.
  - LDA: data.
  - Any other opcode: acc (pass-through).
- zero = (acc==8'h00), evaluated combinationally from the current acc.
- pc is 5 bits and wraps 31->0.
- The last write to a given pc within an instruction wins: JMP overrides the phase-4 increment.
- halt output = halted flag OR (phase==4 AND opcode==HLT).
  - halt rises at the edge that enters phase 4 of an HLT instruction.
  - halt stays 1; the sequencer, pc and acc are frozen until rst.
- Reset mid-instruction: reset wins over all other updates; execution restarts from pc=0, phase 0.
- Timing rule for benches: after the reset cycle, an HLT that is the k-th executed instruction (k from 0) drives halt=1 after exactly 8k+4 rising edges with rst=0, and halt=0 after 8k+3 edges.

Test Plan:
- Reset: mem[0]=HLT; 1 edge with rst=1 -> halt=0.
  - Then with rst=0: halt=0 after 3 edges, halt=1 after 4 edges.
- JMP: mem[0]=mem[1]={JMP,2}, mem[2]=HLT -> halt=0 at 11 edges, halt=1 at 12 edges.
- SKZ:
  - mem[0]=SKZ, mem[1]={JMP,2}, mem[2]=HLT; acc=0 so mem[1] is skipped -> halt at 12 edges, not before.
  - LDA variant: mem[0]={LDA,5}, mem[5]=1, mem[1]=SKZ, mem[2]=HLT; no skip -> halt at 20 edges.
- STO/LDA:
  - Program: mem[0]={LDA,7}, mem[1]={STO,8}, mem[2]={LDA,8}, mem[3]=SKZ, mem[4]=HLT, mem[7]=1, mem[8]=0.
  - Required: mem[8] becomes 1, halt=0 at 35 edges, halt=1 at 36 edges.
- AND/XOR:
  - AND: LDA 8'hFF, AND 8'h01 (nonzero, no skip), JMP, AND 8'hFE (zero, skip), JMP, HLT -> halt at 60 edges.
  - XOR: same program shape with 8'h55 ^ 8'h54 = 8'h01, then ^ 8'h01 = 0 -> halt at 60 edges.
- ADD wrap:
  - Program: LDA 8'hFF, ADD 8'h01 (=0, SKZ skips), ADD 8'h01 (=1, no skip), HLT.
  - Required: acc wraps to 0 with no carry; halt=0 at 43 edges, halt=1 at 44 edges.
